// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM-stage load/store port: wait-stated word read or
// byte-lane-masked write on an internal array, with a stall request back to the pipeline.
module dmem_responder #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        stall_req_o
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned SPAN_W = ADDR_W + 2;
  localparam int unsigned LANES  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [3:0]         sel_q, sel_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        data_q, data_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;

  logic [31:0]        mem [DEPTH];
  logic [31:0]        off_c;
  logic               in_range_c;
  logic [ADDR_W-1:0]  idx_c;
  logic               mem_wr_c;

  // Offset from the mapped base wraps at 32 bits, so addresses below BASE_ADDR fall out of range.
  always_comb begin
    off_c      = addr_q - BASE_ADDR;
    in_range_c = ((off_c >> SPAN_W) == 32'd0);
    idx_c      = off_c[SPAN_W-1:2];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    data_d      = data_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    stall_req_o = 1'b0;
    mem_wr_c    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        stall_req_o = ce_i;
        if (ce_i) begin
          we_d    = we_i;
          sel_d   = sel_i;
          addr_d  = addr_i;
          wdata_d = data_i;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        stall_req_o = 1'b1;
        if (!ce_i) begin
          // Requester withdrew: drop the access silently.
          state_d = ST_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = ST_DONE;
          ack_d   = 1'b1;
          if (!in_range_c) begin
            err_d  = 1'b1;
            data_d = 32'd0;
          end else if (we_q) begin
            mem_wr_c = 1'b1;
            data_d   = 32'd0;
          end else begin
            data_d = mem[idx_c];
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  // Byte-lane write; sel[k] covers data[8k+7:8k]. Array contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst && mem_wr_c) begin
      for (int k = 0; k < LANES; k++) begin
        if (sel_q[k]) begin
          mem[idx_c][8*k +: 8] <= wdata_q[8*k +: 8];
        end
      end
    end
  end

  assign data_o = data_q;
  assign ack_o  = ack_q;
  assign err_o  = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (2 wait states / 4K words at 0, and
// 0 wait states / 16 words at 0x100) checked every cycle against a transaction-level model.
module tb_dmem_responder;

  localparam int unsigned W_A  = 2;
  localparam int unsigned AW_A = 12;
  localparam logic [31:0] BA_A = 32'h0000_0000;
  localparam int unsigned W_B  = 0;
  localparam int unsigned AW_B = 4;
  localparam logic [31:0] BA_B = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst   [2];
  logic        ce    [2];
  logic        we    [2];
  logic [3:0]  sel   [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        ack   [2];
  logic        err   [2];
  logic        stall [2];

  logic        exp_stall [2];
  logic        exp_ack   [2];
  logic        exp_err   [2];
  logic [31:0] exp_data  [2];
  logic [31:0] mdl [int];
  bit          chk_on = 1'b0;
  int          cyc = 0;
  int          start_cyc [2];
  int          n_pass = 0;
  int          n_total = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  dmem_responder #(.ADDR_W(AW_A), .WAIT_CYCLES(W_A), .BASE_ADDR(BA_A)) dut_a (
    .clk(clk), .rst(rst[0]), .ce_i(ce[0]), .we_i(we[0]), .sel_i(sel[0]), .addr_i(addr[0]),
    .data_i(wdata[0]), .data_o(rdata[0]), .ack_o(ack[0]), .err_o(err[0]), .stall_req_o(stall[0])
  );

  dmem_responder #(.ADDR_W(AW_B), .WAIT_CYCLES(W_B), .BASE_ADDR(BA_B)) dut_b (
    .clk(clk), .rst(rst[1]), .ce_i(ce[1]), .we_i(we[1]), .sel_i(sel[1]), .addr_i(addr[1]),
    .data_i(wdata[1]), .data_o(rdata[1]), .ack_o(ack[1]), .err_o(err[1]), .stall_req_o(stall[1])
  );

  function automatic int unsigned wait_of(int u);
    return (u == 0) ? W_A : W_B;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    n_total++;
    if (act !== req) $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, req, $time);
    else n_pass++;
  endtask

  // Model of one completed access: range check, word read, or lane-masked write.
  task automatic model_access(int u, logic w, logic [3:0] s, logic [31:0] a, logic [31:0] d,
                              output logic [31:0] rd, output logic e);
    logic [31:0] base, off, cur;
    int unsigned aw;
    int key;
    base = (u == 0) ? BA_A : BA_B;
    aw   = (u == 0) ? AW_A : AW_B;
    off  = a - base;
    if (64'(off) >= (64'(4) << aw)) begin
      rd = 32'd0;
      e  = 1'b1;
      return;
    end
    e   = 1'b0;
    key = u * 65536 + int'(off >> 2);
    cur = mdl.exists(key) ? mdl[key] : 32'hxxxx_xxxx;
    if (w) begin
      for (int k = 0; k < 4; k++) if (s[k]) cur[8*k +: 8] = d[8*k +: 8];
      mdl[key] = cur;
      rd = 32'd0;
    end else begin
      rd = cur;
    end
  endtask

  task automatic set_idle_exp(int u);
    exp_stall[u] = 1'b0;
    exp_ack[u]   = 1'b0;
    exp_err[u]   = 1'b0;
  endtask

  // One request held for its full lifetime; optionally withdrawn or reset at cycle cut_at.
  task automatic access(int u, logic w, logic [3:0] s, logic [31:0] a, logic [31:0] d,
                        int drop_at = -1, int rst_at = -1);
    int unsigned wc;
    logic [31:0] md;
    logic me;
    wc = wait_of(u);
    for (int i = 0; i <= int'(wc) + 2; i++) begin
      @(posedge clk); #1;
      if (i == 0) start_cyc[u] = cyc;
      ce[u] = 1'b1; we[u] = w; sel[u] = s; addr[u] = a; wdata[u] = d;
      exp_stall[u] = (i <= int'(wc) + 1);
      exp_ack[u]   = 1'b0;
      exp_err[u]   = 1'b0;
      if (i == drop_at) ce[u] = 1'b0;
      if (i == rst_at) rst[u] = 1'b1;
      if (i == drop_at || i == rst_at) begin
        @(posedge clk); #1;
        rst[u] = 1'b0;
        ce[u]  = 1'b0;
        set_idle_exp(u);
        if (i == rst_at) exp_data[u] = 32'd0;
        return;
      end
      if (i == int'(wc) + 2) begin
        model_access(u, w, s, a, d, md, me);
        exp_ack[u]  = 1'b1;
        exp_err[u]  = me;
        exp_data[u] = md;
      end
    end
  endtask

  task automatic idle(int u, int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      ce[u] = 1'b0;
      set_idle_exp(u);
    end
  endtask

  // Every-cycle comparison of both instances against the model expectations.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int u = 0; u < 2; u++) begin
        chk($sformatf("u%0d_stall", u), 32'(stall[u]), 32'(exp_stall[u]));
        chk($sformatf("u%0d_ack", u), 32'(ack[u]), 32'(exp_ack[u]));
        chk($sformatf("u%0d_err", u), 32'(err[u]), 32'(exp_err[u]));
        chk($sformatf("u%0d_data", u), rdata[u], exp_data[u]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int s_prev;
    for (int u = 0; u < 2; u++) begin
      rst[u] = 1'b1; ce[u] = 1'b0; we[u] = 1'b0; sel[u] = '0; addr[u] = '0; wdata[u] = '0;
      set_idle_exp(u);
      exp_data[u] = 32'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    chk_on = 1'b1;
    @(negedge clk);
    chk("rst_a_data", rdata[0], 32'd0);
    chk("rst_b_ack", 32'(ack[1]), 32'd0);

    // Instance A: two wait states, 4K words at 0.
    access(0, 1'b1, 4'b1111, 32'h10, 32'h1122_3344);
    access(0, 1'b0, 4'b1111, 32'h10, 32'h0);
    @(negedge clk);
    chk("a_rd10_data", rdata[0], 32'h1122_3344);
    chk("a_rd10_err", 32'(err[0]), 32'd0);
    chk("a_rd10_latency", 32'(cyc - start_cyc[0]), 32'd4);

    access(0, 1'b1, 4'b0100, 32'h11, 32'hAAAA_AAAA);
    access(0, 1'b0, 4'b1111, 32'h11, 32'h0);
    @(negedge clk);
    chk("a_bytewr", rdata[0], 32'h11AA_3344);

    access(0, 1'b1, 4'b1111, 32'h0, 32'hCAFE_F00D);
    access(0, 1'b1, 4'b1111, 32'h4000, 32'h5555_5555);
    @(negedge clk);
    chk("a_oor_wr_err", 32'(err[0]), 32'd1);
    access(0, 1'b0, 4'b1111, 32'h4000, 32'h0);
    @(negedge clk);
    chk("a_oor_rd_err", 32'(err[0]), 32'd1);
    chk("a_oor_rd_data", rdata[0], 32'd0);
    access(0, 1'b0, 4'b1111, 32'h0, 32'h0);
    @(negedge clk);
    chk("a_oor_no_alias", rdata[0], 32'hCAFE_F00D);

    access(0, 1'b1, 4'b0000, 32'h10, 32'hFFFF_FFFF);
    access(0, 1'b0, 4'b1111, 32'h10, 32'h0);
    @(negedge clk);
    chk("a_sel0_nochange", rdata[0], 32'h11AA_3344);

    access(0, 1'b1, 4'b1111, 32'h20, 32'h0123_4567);
    access(0, 1'b1, 4'b1111, 32'h20, 32'hDEAD_BEEF, 2, -1);
    @(negedge clk);
    chk("a_abort_stall", 32'(stall[0]), 32'd0);
    idle(0, 2);
    access(0, 1'b0, 4'b1111, 32'h20, 32'h0);
    @(negedge clk);
    chk("a_abort_mem8", rdata[0], 32'h0123_4567);

    access(0, 1'b1, 4'b1111, 32'h24, 32'h0BAD_C0DE);
    access(0, 1'b1, 4'b1111, 32'h24, 32'h1234_5678, -1, 1);
    @(negedge clk);
    chk("a_rst_data", rdata[0], 32'd0);
    chk("a_rst_stall", 32'(stall[0]), 32'd0);
    idle(0, 1);
    access(0, 1'b0, 4'b1111, 32'h24, 32'h0);
    @(negedge clk);
    chk("a_rst_mem9", rdata[0], 32'h0BAD_C0DE);

    access(0, 1'b1, 4'b1111, 32'h3FFC, 32'h7777_8888);
    access(0, 1'b0, 4'b1111, 32'h3FFC, 32'h0);
    idle(0, 2);

    // Instance B: zero wait states, 16 words at 0x100.
    access(1, 1'b1, 4'b1111, 32'h100, 32'hA5A5_A5A5);
    access(1, 1'b0, 4'b1111, 32'h100, 32'h0);
    @(negedge clk);
    chk("b_rd_latency", 32'(cyc - start_cyc[1]), 32'd2);
    s_prev = start_cyc[1];
    access(1, 1'b0, 4'b0001, 32'h100, 32'h0);
    @(negedge clk);
    chk("b_b2b_accept", 32'(start_cyc[1] - s_prev), 32'd3);
    chk("b_b2b_data", rdata[1], 32'hA5A5_A5A5);

    access(1, 1'b1, 4'b1111, 32'h13C, 32'h600D_F00D);
    access(1, 1'b0, 4'b1111, 32'h140, 32'h0);
    @(negedge clk);
    chk("b_past_top_err", 32'(err[1]), 32'd1);
    access(1, 1'b1, 4'b1111, 32'hFC, 32'hBBBB_BBBB);
    access(1, 1'b0, 4'b1111, 32'h13C, 32'h0);
    @(negedge clk);
    chk("b_below_base", rdata[1], 32'h600D_F00D);

    access(1, 1'b1, 4'b1111, 32'h104, 32'h0000_0001);
    access(1, 1'b1, 4'b1111, 32'h104, 32'hFFFF_0000, 1, -1);
    idle(1, 1);
    access(1, 1'b1, 4'b1111, 32'h104, 32'hEEEE_0000, -1, 1);
    idle(1, 1);
    access(1, 1'b0, 4'b1111, 32'h104, 32'h0);
    @(negedge clk);
    chk("b_abort_rst_mem", rdata[1], 32'h0000_0001);
    idle(1, 2);

    @(negedge clk);
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
